change_dispenser: RTL and testbench
===================================

CHANGE_DISPENSER -- requirements
Module: change_dispenser

Interface
REQ-001 The block SHALL have the port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-002 The block SHALL have the port rst_n, input, 1 bit: synchronous reset, active-low.
REQ-003 The block SHALL have the port load, input, 1 bit: request to dispense change for amount; sampled only in IDLE.
REQ-004 The block SHALL have the port amount, input, 8 bits: change owed, in cents, unsigned 0..255.
REQ-005 The block SHALL have the port coin_valid, output, 1 bit: a coin is presented on coin_type.
REQ-006 The block SHALL have the port coin_type, output, 2 bits: 00 = nickel (5), 01 = dime (10), 10 = quarter (25), 11 = dollar (100).
REQ-007 The block SHALL have the port coin_ready, input, 1 bit: the downstream ejector accepts the presented coin.
REQ-008 The block SHALL have the port busy, output, 1 bit: high in DISPENSE and DONE.
REQ-009 The block SHALL have the port done, output, 1 bit: one-cycle pulse when a transaction completes.
REQ-010 The block SHALL have the port err, output, 1 bit: one-cycle pulse when a load is rejected.
REQ-011 The block SHALL have the port coin_count, output, 6 bits: coins accepted in the current or most recent transaction.

Function
REQ-012 The FSM SHALL have three states, IDLE, DISPENSE and DONE, held in a registered state variable.
REQ-013 In IDLE, with load=1 and amount%5 != 0, the block SHALL pulse err for the next cycle and remain in IDLE, leaving coin_count unchanged.
REQ-014 In IDLE, with load=1 and amount=0, the block SHALL go to DONE, clear coin_count and present no coin.
REQ-015 In IDLE, with load=1 and a valid nonzero amount, the block SHALL capture amount into an 8-bit remaining register, clear coin_count and go to DISPENSE.
REQ-016 In DISPENSE, coin_valid SHALL be 1 and coin_type SHALL be registered-derived from remaining as the largest enabled coin value <= remaining (greedy).
REQ-017 coin_type SHALL stay stable while coin_valid=1 and coin_ready=0; coin_valid SHALL NOT drop without acceptance.
REQ-018 On a cycle with coin_valid and coin_ready both high, the block SHALL subtract the coin value from remaining and increment coin_count, with at most one coin accepted per cycle.
REQ-019 When the post-subtraction remaining equals 0, the block SHALL go to DONE on that same edge; otherwise it SHALL stay in DISPENSE and present the next coin the following cycle.
REQ-020 In DONE, done SHALL be 1 for exactly one cycle, coin_valid SHALL be 0, and the next state SHALL be IDLE.
REQ-021 load SHALL be ignored while busy=1, with no err and no effect on remaining.
REQ-022 coin_valid, done and err SHALL be mutually exclusive in any cycle.
REQ-023 remaining SHALL never underflow; the greedy choice guarantees coin value <= remaining.
REQ-024 Latency SHALL be as follows: the first coin_valid appears in the cycle after the load edge, and with coin_ready tied high, N coins take N cycles followed by the done cycle.

Reset
REQ-025 While rst_n=0 at a rising edge, the block SHALL set state=IDLE, remaining=0, coin_count=0, coin_valid=0, done=0, err=0, coin_type=00 and busy=0.
REQ-026 A reset asserted mid-DISPENSE SHALL abort the transaction, and no done pulse SHALL be produced.
REQ-027 The first cycle with rst_n=1 SHALL act as IDLE and SHALL accept load.

Configuration
REQ-028 With macro DISPENSER_DOLLAR_COIN_EN defined, the dollar coin (11, value 100) SHALL be eligible in the greedy choice.
REQ-029 With DISPENSER_DOLLAR_COIN_EN undefined, the largest coin SHALL be the quarter, coin_type 11 SHALL never be emitted, and all other behaviour SHALL be identical.

Verification
REQ-030 The bench SHALL apply load with amount=40 and coin_ready=1, and SHALL check coin_type sequence 10, 01, 00, then a done pulse and coin_count=3.
REQ-031 The bench SHALL apply load with amount=255 and coin_ready=1, and SHALL check:
- with DISPENSER_DOLLAR_COIN_EN: 11, 11, 10, 10, 00 and coin_count=5;
- without it: ten 10 then one 00 and coin_count=11.
REQ-032 The bench SHALL apply load with amount=30, hold coin_ready=0 for 4 cycles and then set it to 1, and SHALL check that coin_type stays 10 while stalled, then 00, then done.
REQ-033 The bench SHALL apply load with amount=37, and SHALL check an err pulse, no coin_valid and a return to IDLE; it SHALL also apply load with amount=0 and check a done pulse with coin_count=0.
REQ-034 The bench SHALL apply load with amount=50, pulse load with amount=5 mid-dispense, and assert rst_n=0 after the first accept, and SHALL check:
- the second load is ignored;
- after reset, outputs match REQ-025 with no done pulse.

Source files
------------

// File: rtl/change_dispenser.sv
// change_dispenser
// Greedy coin dispenser. A load in IDLE captures the amount owed (cents) and
// the block then presents one coin at a time on a valid/ready handshake,
// largest eligible coin first, until nothing remains. It then pulses done.
// Amounts that are not a multiple of five are rejected with a one-cycle err.
//
// Build option:
//   DISPENSER_DOLLAR_COIN_EN - when defined, the dollar coin (type 11, 100c)
//                              is eligible in the greedy choice. When undefined,
//                              the quarter is the largest coin and type 11 is
//                              never emitted.
//
// All outputs are registered. They are derived from the next-state values so
// that they line up with the state they describe.

module change_dispenser (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       load,
   input  logic [7:0] amount,
   output logic       coin_valid,
   output logic [1:0] coin_type,
   input  logic       coin_ready,
   output logic       busy,
   output logic       done,
   output logic       err,
   output logic [5:0] coin_count
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'b00,
      ST_DISPENSE = 2'b01,
      ST_DONE     = 2'b10
   } state_t;

   localparam logic [1:0] COIN_NICKEL  = 2'b00;
   localparam logic [1:0] COIN_DIME    = 2'b01;
   localparam logic [1:0] COIN_QUARTER = 2'b10;
   localparam logic [1:0] COIN_DOLLAR  = 2'b11;

   // Face value in cents of a coin type.
   function automatic logic [7:0] coin_value(input logic [1:0] ctype);
      logic [7:0] val;
      case (ctype)
         COIN_NICKEL:  val = 8'd5;
         COIN_DIME:    val = 8'd10;
         COIN_QUARTER: val = 8'd25;
         COIN_DOLLAR:  val = 8'd100;
         default:      val = 8'd5;
      endcase
      return val;
   endfunction

   // Largest eligible coin whose value does not exceed rem. Because rem is
   // always a nonzero multiple of five while dispensing, the chosen coin never
   // exceeds rem, so the subtraction cannot underflow.
   function automatic logic [1:0] greedy_coin(input logic [7:0] rem);
      logic [1:0] ctype;
`ifdef DISPENSER_DOLLAR_COIN_EN
      if (rem >= 8'd100) begin
         ctype = COIN_DOLLAR;
      end else if (rem >= 8'd25) begin
         ctype = COIN_QUARTER;
      end else if (rem >= 8'd10) begin
         ctype = COIN_DIME;
      end else begin
         ctype = COIN_NICKEL;
      end
`else
      if (rem >= 8'd25) begin
         ctype = COIN_QUARTER;
      end else if (rem >= 8'd10) begin
         ctype = COIN_DIME;
      end else begin
         ctype = COIN_NICKEL;
      end
`endif
      return ctype;
   endfunction

   // True when the amount can be paid exactly in nickels and larger coins.
   function automatic logic amount_is_payable(input logic [7:0] amt);
      logic [7:0] rem5;
      rem5 = amt % 8'd5;
      return (rem5 == 8'd0);
   endfunction

   state_t     state_q,      state_d;
   logic [7:0] remaining_q,  remaining_d;
   logic [5:0] coin_count_q, coin_count_d;
   logic       coin_valid_q, coin_valid_d;
   logic [1:0] coin_type_q,  coin_type_d;
   logic       busy_q,       busy_d;
   logic       done_q,       done_d;
   logic       err_q,        err_d;

   logic       accept_s;
   logic [7:0] coin_val_s;

   assign accept_s   = coin_valid_q & coin_ready;
   assign coin_val_s = coin_value(coin_type_q);

   // Next-state, remaining-amount and coin-count logic.
   always_comb begin
      state_d      = state_q;
      remaining_d  = remaining_q;
      coin_count_d = coin_count_q;
      err_d        = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (load) begin
               if (!amount_is_payable(amount)) begin
                  // Rejected load: stay idle, leave the last count visible.
                  err_d = 1'b1;
               end else if (amount == 8'd0) begin
                  // Nothing owed: finish straight away with zero coins.
                  remaining_d  = 8'd0;
                  coin_count_d = 6'd0;
                  state_d      = ST_DONE;
               end else begin
                  remaining_d  = amount;
                  coin_count_d = 6'd0;
                  state_d      = ST_DISPENSE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_DISPENSE: begin
            // load is deliberately not looked at here.
            if (accept_s) begin
               remaining_d  = remaining_q - coin_val_s;
               coin_count_d = coin_count_q + 6'd1;
               if (remaining_d == 8'd0) begin
                  state_d = ST_DONE;
               end else begin
                  state_d = ST_DISPENSE;
               end
            end else begin
               state_d = ST_DISPENSE;
            end
         end

         ST_DONE: begin
            state_d = ST_IDLE;
         end

         default: begin
            state_d     = ST_IDLE;
            remaining_d = 8'd0;
         end
      endcase
   end

   // Output values for the coming cycle, derived from the next state so that
   // the registered outputs describe the state they are presented with.
   always_comb begin
      coin_valid_d = 1'b0;
      coin_type_d  = COIN_NICKEL;
      busy_d       = 1'b0;
      done_d       = 1'b0;

      case (state_d)
         ST_IDLE: begin
            coin_valid_d = 1'b0;
            busy_d       = 1'b0;
         end
         ST_DISPENSE: begin
            // While stalled remaining_d is unchanged, so coin_type holds.
            coin_valid_d = 1'b1;
            coin_type_d  = greedy_coin(remaining_d);
            busy_d       = 1'b1;
         end
         ST_DONE: begin
            busy_d = 1'b1;
            done_d = 1'b1;
         end
         default: begin
            coin_valid_d = 1'b0;
            busy_d       = 1'b0;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         remaining_q  <= 8'd0;
         coin_count_q <= 6'd0;
         coin_valid_q <= 1'b0;
         coin_type_q  <= COIN_NICKEL;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
      end else begin
         state_q      <= state_d;
         remaining_q  <= remaining_d;
         coin_count_q <= coin_count_d;
         coin_valid_q <= coin_valid_d;
         coin_type_q  <= coin_type_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         err_q        <= err_d;
      end
   end

   assign coin_valid = coin_valid_q;
   assign coin_type  = coin_type_q;
   assign busy       = busy_q;
   assign done       = done_q;
   assign err        = err_q;
   assign coin_count = coin_count_q;

endmodule

// File: tb/tb_change_dispenser.sv
// tb_change_dispenser
// Directed bench for change_dispenser. Inputs are driven and outputs sampled
// on the falling clock edge. Expected coin sequences are hand-computed; the
// 255-cent case follows DISPENSER_DOLLAR_COIN_EN when it is defined.

module tb_change_dispenser;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       load;
   logic [7:0] amount;
   logic       coin_valid;
   logic [1:0] coin_type;
   logic       coin_ready;
   logic       busy;
   logic       done;
   logic       err;
   logic [5:0] coin_count;

   int   total = 0;
   int   bad   = 0;
   logic mon_en = 1'b0;

   logic [1:0] exp_q[$];

   always #5 clk = ~clk;

   change_dispenser dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .load       (load),
      .amount     (amount),
      .coin_valid (coin_valid),
      .coin_type  (coin_type),
      .coin_ready (coin_ready),
      .busy       (busy),
      .done       (done),
      .err        (err),
      .coin_count (coin_count)
   );

   task automatic check(input string tag, input logic [7:0] got, input logic [7:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // coin_valid, done and err must never be high together.
   always @(negedge clk) begin
      if (mon_en) begin
         check("mutex", {7'd0, ($countones({coin_valid, done, err}) <= 1)}, 8'd1);
      end
   end

   task automatic do_load(input logic [7:0] a);
      amount = a;
      load   = 1'b1;
      @(negedge clk);
      load   = 1'b0;
   endtask

   // Walks the coins in exp_q with coin_ready high, then checks the done cycle.
   task automatic run_coins(input string tag, input logic [5:0] n);
      for (int i = 0; i < exp_q.size(); i++) begin
         check({tag, "_valid"}, {7'd0, coin_valid}, 8'd1);
         check({tag, "_type"}, {6'd0, coin_type}, {6'd0, exp_q[i]});
         @(negedge clk);
      end
      check({tag, "_done"}, {7'd0, done}, 8'd1);
      check({tag, "_dvalid"}, {7'd0, coin_valid}, 8'd0);
      check({tag, "_count"}, {2'd0, coin_count}, {2'd0, n});
      check({tag, "_dbusy"}, {7'd0, busy}, 8'd1);
      @(negedge clk);
      check({tag, "_done_off"}, {7'd0, done}, 8'd0);
      check({tag, "_idle"}, {7'd0, busy}, 8'd0);
   endtask

   initial begin
      rst_n      = 1'b0;
      load       = 1'b0;
      amount     = 8'd0;
      coin_ready = 1'b1;
      repeat (2) @(negedge clk);
      check("rst_valid", {7'd0, coin_valid}, 8'd0);
      check("rst_type", {6'd0, coin_type}, 8'd0);
      check("rst_busy", {7'd0, busy}, 8'd0);
      check("rst_done", {7'd0, done}, 8'd0);
      check("rst_err", {7'd0, err}, 8'd0);
      check("rst_count", {2'd0, coin_count}, 8'd0);
      mon_en = 1'b1;
      rst_n  = 1'b1;
      @(negedge clk);

      // 40 = 25 + 10 + 5
      exp_q = '{2'b10, 2'b01, 2'b00};
      do_load(8'd40);
      run_coins("a40", 6'd3);

      // 255 cents
      exp_q.delete();
`ifdef DISPENSER_DOLLAR_COIN_EN
      exp_q = '{2'b11, 2'b11, 2'b10, 2'b10, 2'b00};
      do_load(8'd255);
      run_coins("a255", 6'd5);
`else
      for (int i = 0; i < 10; i++) exp_q.push_back(2'b10);
      exp_q.push_back(2'b00);
      do_load(8'd255);
      run_coins("a255", 6'd11);
`endif

      // 30 with the ejector stalled for four cycles
      coin_ready = 1'b0;
      do_load(8'd30);
      for (int i = 0; i < 4; i++) begin
         check("stall_valid", {7'd0, coin_valid}, 8'd1);
         check("stall_type", {6'd0, coin_type}, 8'd2);
         check("stall_count", {2'd0, coin_count}, 8'd0);
         @(negedge clk);
      end
      coin_ready = 1'b1;
      check("stall_type_rel", {6'd0, coin_type}, 8'd2);
      @(negedge clk);
      check("stall_nickel_v", {7'd0, coin_valid}, 8'd1);
      check("stall_nickel", {6'd0, coin_type}, 8'd0);
      check("stall_cnt1", {2'd0, coin_count}, 8'd1);
      @(negedge clk);
      check("stall_done", {7'd0, done}, 8'd1);
      check("stall_cnt2", {2'd0, coin_count}, 8'd2);
      @(negedge clk);

      // 37 is not payable: err pulse, count unchanged, stay idle
      do_load(8'd37);
      check("e37_err", {7'd0, err}, 8'd1);
      check("e37_valid", {7'd0, coin_valid}, 8'd0);
      check("e37_busy", {7'd0, busy}, 8'd0);
      check("e37_count", {2'd0, coin_count}, 8'd2);
      @(negedge clk);
      check("e37_err_off", {7'd0, err}, 8'd0);
      check("e37_idle_v", {7'd0, coin_valid}, 8'd0);
      check("e37_idle_b", {7'd0, busy}, 8'd0);

      // 0 cents: immediate done with zero coins
      do_load(8'd0);
      check("z_done", {7'd0, done}, 8'd1);
      check("z_count", {2'd0, coin_count}, 8'd0);
      check("z_valid", {7'd0, coin_valid}, 8'd0);
      @(negedge clk);
      check("z_done_off", {7'd0, done}, 8'd0);
      check("z_idle", {7'd0, busy}, 8'd0);

      // 50 with a stray load mid-dispense, then reset after the first accept
      do_load(8'd50);
      check("r_valid", {7'd0, coin_valid}, 8'd1);
      check("r_type", {6'd0, coin_type}, 8'd2);
      amount = 8'd5;
      load   = 1'b1;
      @(negedge clk);
      load   = 1'b0;
      check("r_ign_type", {6'd0, coin_type}, 8'd2);
      check("r_ign_count", {2'd0, coin_count}, 8'd1);
      check("r_ign_err", {7'd0, err}, 8'd0);
      check("r_ign_busy", {7'd0, busy}, 8'd1);
      rst_n = 1'b0;
      @(negedge clk);
      check("r_rst_valid", {7'd0, coin_valid}, 8'd0);
      check("r_rst_type", {6'd0, coin_type}, 8'd0);
      check("r_rst_busy", {7'd0, busy}, 8'd0);
      check("r_rst_done", {7'd0, done}, 8'd0);
      check("r_rst_err", {7'd0, err}, 8'd0);
      check("r_rst_count", {2'd0, coin_count}, 8'd0);
      @(negedge clk);
      check("r_rst_done2", {7'd0, done}, 8'd0);

      // first cycle out of reset accepts a load
      rst_n = 1'b1;
      do_load(8'd5);
      check("p_valid", {7'd0, coin_valid}, 8'd1);
      check("p_type", {6'd0, coin_type}, 8'd0);
      @(negedge clk);
      check("p_done", {7'd0, done}, 8'd1);
      check("p_count", {2'd0, coin_count}, 8'd1);
      @(negedge clk);

      mon_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
